hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and branch-operand stalls, control-transfer flush.
// Stall/flush outputs are combinational; a two-state FSM adds the second stall cycle
// needed when a branch in ID depends on a load still in EX.
// Optional statistics counters are built only when HAZARD_STATS_EN is defined;
// otherwise stall_cnt/flush_cnt are tied to zero.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs_ID,
  input  logic [4:0]  rt_ID,
  input  logic        use_rt_ID,
  input  logic        branch_ID,
  input  logic        branch_taken_ID,
  input  logic        jump_ID,
  input  logic        RegWrite_EX,
  input  logic        MemtoReg_EX,
  input  logic [4:0]  dst_EX,
  input  logic        RegWrite_MEM,
  input  logic        MemtoReg_MEM,
  input  logic [4:0]  dst_MEM,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        ifid_clear,
  output logic        idex_clear,
  output logic        stalling,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic {StRun = 1'b0, StHold = 1'b1} state_e;

  state_e     r_state;
  logic [1:0] w_need;
  logic       w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt;
  logic       w_ex_load, w_mem_load;
  logic       w_stall, w_flush;

  // Hazard depth: register matches against r0 never count.
  always_comb begin
    w_ex_rs    = (dst_EX != 5'd0) && (dst_EX == rs_ID);
    w_ex_rt    = (dst_EX != 5'd0) && (dst_EX == rt_ID);
    w_mem_rs   = (dst_MEM != 5'd0) && (dst_MEM == rs_ID);
    w_mem_rt   = (dst_MEM != 5'd0) && (dst_MEM == rt_ID);
    w_ex_load  = RegWrite_EX && MemtoReg_EX;
    w_mem_load = RegWrite_MEM && MemtoReg_MEM;
    w_need     = 2'd0;
    if (branch_ID && w_ex_load && (w_ex_rs || w_ex_rt)) begin
      w_need = 2'd2;
    end else if ((w_ex_load && (w_ex_rs || (w_ex_rt && use_rt_ID))) ||
                 (branch_ID && RegWrite_EX && !MemtoReg_EX && (w_ex_rs || w_ex_rt)) ||
                 (branch_ID && w_mem_load && (w_mem_rs || w_mem_rt))) begin
      w_need = 2'd1;
    end
  end

  // Stall beats flush; HOLD ignores hazard inputs entirely.
  always_comb begin
    w_stall = rst_n && ((r_state == StHold) || (w_need != 2'd0));
    w_flush = rst_n && (r_state == StRun) && (w_need == 2'd0) &&
              (jump_ID || (branch_ID && branch_taken_ID));
    if (!rst_n) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      ifid_clear = 1'b1;
      idex_clear = 1'b1;
    end else begin
      pc_we      = !w_stall;
      ifid_we    = !w_stall;
      ifid_clear = w_flush;
      idex_clear = w_stall;
    end
    stalling = (r_state == StHold);
  end

  // RUN -> HOLD only for the two-deep hazard; HOLD always lasts exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StRun;
    end else begin
      unique case (r_state)
        StRun:   r_state <= (w_need == 2'd2) ? StHold : StRun;
        StHold:  r_state <= StRun;
        default: r_state <= StRun;
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] r_stall_cnt, r_flush_cnt;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      if (w_stall && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_flush && (r_flush_cnt != 16'hFFFF)) r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = 16'd0;
  assign flush_cnt = 16'd0;
`endif

endmodule
